// File: rtl/alien_laser_ctrl_pkg.sv
// Shared constants and slot state encoding for the alien laser controller.
package alien_laser_ctrl_pkg;
  localparam int unsigned NUM_LASERS = 3;
  localparam int unsigned COORD_W    = 10;
  localparam logic [9:0]  LASER_H    = 10'd10;
  localparam logic [9:0]  BOTTOM_Y   = 10'd470;
  localparam logic [9:0]  PARK_X     = 10'd0;
  localparam logic [9:0]  PARK_Y     = 10'd0;
  localparam logic [7:0]  LFSR_SEED  = 8'hA5;

  typedef enum logic {
    SLOT_IDLE = 1'b0,
    SLOT_FLY  = 1'b1
  } slot_state_e;

  // 11-bit sum so a laser near the bottom can never wrap back to the top
  function automatic logic [10:0] step_y(input logic [9:0] y, input logic [9:0] spd);
    return {1'b0, y} + {1'b0, spd};
  endfunction
endpackage

// File: rtl/alien_laser_ctrl_if.sv
// Fire request handshake between the alien formation and the laser controller.
interface alien_laser_ctrl_if;
  logic       fire_req;
  logic [9:0] fire_x;
  logic [9:0] fire_y;
  logic       fire_ack;

  modport master (output fire_req, output fire_x, output fire_y, input fire_ack);
  modport slave  (input fire_req, input fire_x, input fire_y, output fire_ack);
endinterface

// File: rtl/alien_laser_ctrl_laser_slot.sv
// One alien laser slot: IDLE/FLY state, coordinate registers, move and retire.
module laser_slot
  import alien_laser_ctrl_pkg::*;
#(
  parameter logic [9:0] LASER_SPEED = 10'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_mode,
  input  logic       i_frame_tick,
  input  logic       i_load,
  input  logic [9:0] i_load_x,
  input  logic [9:0] i_load_y,
  input  logic       i_hit,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_active
);
  slot_state_e r_state;
  slot_state_e w_next;
  logic [10:0] w_next_y;
  logic        w_retire;
  logic [9:0]  r_x;
  logic [9:0]  r_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= SLOT_IDLE;
    else     r_state <= w_next;
  end

  // Priority: mode clear > hit > bottom retire > move
  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    w_next_y = step_y(r_y, LASER_SPEED);
    if (!i_mode) begin
      w_next = SLOT_IDLE;
    end else begin
      case (r_state)
        SLOT_IDLE: if (i_load) w_next = SLOT_FLY;
        SLOT_FLY: begin
          if (i_hit)                                          w_retire = 1'b1;
          else if (i_frame_tick && (w_next_y > {1'b0, BOTTOM_Y})) w_retire = 1'b1;
          if (w_retire) w_next = SLOT_IDLE;
        end
        default: w_next = SLOT_IDLE;
      endcase
    end
  end

  always_comb begin
    o_active = (r_state == SLOT_FLY);
    o_x      = r_x;
    o_y      = r_y;
  end

  // Coordinates are parked on retire so the bus stays a pure register output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x <= PARK_X;
      r_y <= PARK_Y;
    end else if (!i_mode || w_retire) begin
      r_x <= PARK_X;
      r_y <= PARK_Y;
    end else if (r_state == SLOT_IDLE && i_load) begin
      r_x <= i_load_x;
      r_y <= i_load_y;
    end else if (r_state == SLOT_FLY && i_frame_tick) begin
      r_y <= w_next_y[9:0];
    end
  end
endmodule

// File: rtl/alien_laser_ctrl.sv
// Alien laser controller: slot selection, fire cooldown and fire_ack.
// Optional random shot gate enabled by defining ALIEN_LASER_LFSR_EN.
module alien_laser_ctrl
  import alien_laser_ctrl_pkg::*;
#(
  parameter logic [9:0] LASER_SPEED   = 10'd4,
  parameter logic [7:0] FIRE_COOLDOWN = 8'd30
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic                      frame_tick,
  alien_laser_ctrl_if.slave         fire_if,
  input  logic [NUM_LASERS-1:0]     barrierHit,
  input  logic [NUM_LASERS-1:0]     shipHit,
  output logic [10*NUM_LASERS-1:0]  alienLaserXcoord,
  output logic [10*NUM_LASERS-1:0]  alienLaserYcoord,
  output logic [NUM_LASERS-1:0]     laserActive
);
  logic [NUM_LASERS-1:0] w_active;
  logic [NUM_LASERS-1:0] w_sel;
  logic                  w_any_idle;
  logic                  w_gate;
  logic                  w_accept;
  logic [7:0]            r_cooldown;
  logic                  r_fire_ack;

  always_comb begin
    w_sel      = '0;
    w_any_idle = 1'b0;
    for (int unsigned n = 0; n < NUM_LASERS; n++) begin
      if (!w_active[n] && !w_any_idle) begin
        w_sel[n]   = 1'b1;
        w_any_idle = 1'b1;
      end
    end
  end

`ifdef ALIEN_LASER_LFSR_EN
  logic [7:0] r_lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_lfsr <= LFSR_SEED;
    else if (!mode)      r_lfsr <= LFSR_SEED;
    else if (frame_tick) r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  assign w_gate = (r_lfsr[1:0] == 2'b00);
`else
  assign w_gate = 1'b1;
`endif

  assign w_accept = mode && fire_if.fire_req && (r_cooldown == '0) && w_any_idle &&
                    (fire_if.fire_y <= BOTTOM_Y) && !r_fire_ack && w_gate;

  // A load on a tick cycle takes precedence, so that tick does not count down
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cooldown <= '0;
      r_fire_ack <= 1'b0;
    end else begin
      r_fire_ack <= w_accept;
      if (!mode)                              r_cooldown <= '0;
      else if (w_accept)                      r_cooldown <= FIRE_COOLDOWN;
      else if (frame_tick && r_cooldown != '0) r_cooldown <= r_cooldown - 8'd1;
    end
  end

  assign fire_if.fire_ack = r_fire_ack;
  assign laserActive      = w_active;

  for (genvar g = 0; g < NUM_LASERS; g++) begin : g_slot
    laser_slot #(.LASER_SPEED(LASER_SPEED)) u_slot (
      .clk          (clk),
      .rst          (rst),
      .i_mode       (mode),
      .i_frame_tick (frame_tick),
      .i_load       (w_accept && w_sel[g]),
      .i_load_x     (fire_if.fire_x),
      .i_load_y     (fire_if.fire_y),
      .i_hit        (barrierHit[g] || shipHit[g]),
      .o_x          (alienLaserXcoord[10*g +: 10]),
      .o_y          (alienLaserYcoord[10*g +: 10]),
      .o_active     (w_active[g])
    );
  end
endmodule
